// File: rtl/encode_scheduler.sv
// Round-robin scheduler that shares one packet encoder among four request nodes.
// Optional HOLD timeout with drop pulse is enabled by defining ENC_TIMEOUT_EN.
module encode_scheduler #(
  parameter int NODES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NODES-1:0]   req,
  input  logic [NODES*29-1:0] node_pkt,
  output logic [NODES-1:0]   grant,
  output logic [28:0]        enc_in,
  input  logic [54:0]        enc_pkt,
  output logic [54:0]        pkt_out,
  output logic               pkt_valid,
  input  logic               out_ready,
  output logic [1:0]         token,
  output logic               drop_err
);

  localparam int PKT_W = 29;

  typedef enum logic [1:0] {IDLE, ENCODE, HOLD} state_t;

  state_t             state_q, state_d;
  logic [1:0]         win, idx, win_q, win_d, token_d;
  logic               hit;
  logic [NODES-1:0]   grant_d;
  logic [PKT_W-1:0]   enc_in_d;
  logic [54:0]        pkt_out_d;
  logic               pkt_valid_d;

`ifdef ENC_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT = 4'd15;
  logic [3:0] cnt_q, cnt_d;
  logic       drop_q, drop_d;
  assign drop_err = drop_q;
`else
  assign drop_err = 1'b0;
`endif

  // Search starts at the token and wraps, so the node just served is checked last.
  always_comb begin : arbiter
    win = token;
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < NODES; i++) begin
      idx = token + 2'(i);
      if (!hit && req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end

  always_comb begin : next_state
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    grant_d     = grant;
    enc_in_d    = enc_in;
    win_d       = win_q;
    pkt_out_d   = pkt_out;
    pkt_valid_d = pkt_valid;
    token_d     = token;
`ifdef ENC_TIMEOUT_EN
    cnt_d  = cnt_q;
    drop_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (hit) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          enc_in_d     = node_pkt[32'(win)*PKT_W +: PKT_W];
          win_d        = win;
          state_d      = ENCODE;
        end
      end
      ENCODE: begin
        pkt_out_d   = enc_pkt;
        pkt_valid_d = 1'b1;
        grant_d     = '0;
        state_d     = HOLD;
`ifdef ENC_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      HOLD: begin
        if (out_ready) begin
          pkt_valid_d = 1'b0;
          token_d     = win_q + 2'd1;
          state_d     = IDLE;
        end
`ifdef ENC_TIMEOUT_EN
        else if (cnt_q == TIMEOUT - 4'd1) begin
          // This stalled cycle is the 15th: give up on the packet and move the token on.
          pkt_valid_d = 1'b0;
          drop_d      = 1'b1;
          token_d     = win_q + 2'd1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant     <= '0;
      enc_in    <= '0;
      win_q     <= '0;
      pkt_out   <= '0;
      pkt_valid <= 1'b0;
      token     <= '0;
`ifdef ENC_TIMEOUT_EN
      cnt_q  <= '0;
      drop_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant     <= grant_d;
      enc_in    <= enc_in_d;
      win_q     <= win_d;
      pkt_out   <= pkt_out_d;
      pkt_valid <= pkt_valid_d;
      token     <= token_d;
`ifdef ENC_TIMEOUT_EN
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
`endif
    end
  end

endmodule

// File: tb/tb_encode_scheduler.sv
// Self-checking bench for encode_scheduler: directed scenarios plus randomized
// transactions checked against a token/winner model; timeout checks follow ENC_TIMEOUT_EN.
module tb_encode_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [115:0] node_pkt;
  logic [3:0]   grant;
  logic [28:0]  enc_in;
  logic [54:0]  enc_pkt;
  logic [54:0]  pkt_out;
  logic         pkt_valid;
  logic         out_ready;
  logic [1:0]   token;
  logic         drop_err;

  int total = 0;
  int bad   = 0;
  int tok_m = 0;

  encode_scheduler #(.NODES(4)) dut (
    .clk(clk), .rst(rst), .req(req), .node_pkt(node_pkt), .grant(grant),
    .enc_in(enc_in), .enc_pkt(enc_pkt), .pkt_out(pkt_out), .pkt_valid(pkt_valid),
    .out_ready(out_ready), .token(token), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  // Stand-in encoder: any injective function of enc_in will do.
  function automatic logic [54:0] enc_f(input logic [28:0] x);
    return {~x[25:0], x};
  endfunction

  assign enc_pkt = enc_f(enc_in);

  // Winner = first requester found walking forward from the token, modulo 4.
  function automatic int pick(input logic [3:0] r, input int t);
    for (int k = 0; k < 4; k++)
      if (r[(t + k) % 4]) return (t + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int w);
    logic [3:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pkts;
    for (int i = 0; i < 4; i++) node_pkt[29*i +: 29] = 29'($urandom);
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; out_ready = 1'b0; node_pkt = '0;
    step();
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL rst_grant: got %b exp 0000", grant); end
    total++; if (enc_in !== 29'b0) begin bad++; $display("FAIL rst_enc_in: got %h exp 0", enc_in); end
    total++; if (pkt_out !== 55'b0) begin bad++; $display("FAIL rst_pkt_out: got %h exp 0", pkt_out); end
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL rst_pkt_valid: got %b exp 0", pkt_valid); end
    total++; if (token !== 2'd0) begin bad++; $display("FAIL rst_token: got %0d exp 0", token); end
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL rst_drop_err: got %b exp 0", drop_err); end
    rst = 1'b0;
    tok_m = 0;
  endtask

  task automatic test_directed;
    rand_pkts();
    node_pkt[29*2 +: 29] = 29'h1ABCDE0;
    req = 4'b0100; out_ready = 1'b1;
    step();
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL dir_grant: got %b exp 0100", grant); end
    total++; if (enc_in !== 29'h1ABCDE0) begin bad++; $display("FAIL dir_enc_in: got %h exp 1abcde0", enc_in); end
    req = 4'b0000;
    step();
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL dir_grant_drop: got %b exp 0000", grant); end
    total++; if (pkt_valid !== 1'b1) begin bad++; $display("FAIL dir_valid: got %b exp 1", pkt_valid); end
    total++; if (pkt_out !== enc_f(29'h1ABCDE0)) begin bad++; $display("FAIL dir_pkt_out: got %h exp %h", pkt_out, enc_f(29'h1ABCDE0)); end
    step();
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL dir_valid_fall: got %b exp 0", pkt_valid); end
    total++; if (token !== 2'd3) begin bad++; $display("FAIL dir_token: got %0d exp 3", token); end
    tok_m = 3;
  endtask

  task automatic test_wrap;
    logic [3:0] exp_g [2];
    logic [1:0] exp_t [2];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010;
    exp_t[0] = 2'd1;    exp_t[1] = 2'd2;
    req = 4'b0011; out_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      rand_pkts();
      step();
      total++; if (grant !== exp_g[p]) begin bad++; $display("FAIL wrap_grant%0d: got %b exp %b", p, grant, exp_g[p]); end
      step();
      step();
      total++; if (token !== exp_t[p]) begin bad++; $display("FAIL wrap_token%0d: got %0d exp %0d", p, token, exp_t[p]); end
    end
    req = 4'b0000;
    tok_m = 2;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    req = 4'b1111; out_ready = 1'b1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tok_m = 0;
    for (int p = 0; p < 5; p++) begin
      rand_pkts();
      step();
      total++; if (grant !== exp_g[p]) begin bad++; $display("FAIL rr_grant%0d: got %b exp %b", p, grant, exp_g[p]); end
      rand_pkts();
      step();
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL rr_grant_low%0d: got %b exp 0000", p, grant); end
      step();
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL rr_grant_hold%0d: got %b exp 0000", p, grant); end
    end
    req = 4'b0000;
    tok_m = 1;
  endtask

  task automatic test_stall;
    logic [28:0] pkt;
    int w;
    rand_pkts();
    req = 4'b0001; out_ready = 1'b0;
    w = pick(req, tok_m);
    pkt = node_pkt[29*w +: 29];
    step();
    req = 4'b0000;
    step();
    for (int c = 0; c < 5; c++) begin
      req = 4'($urandom_range(1, 15));
      rand_pkts();
      step();
      total++; if (pkt_out !== enc_f(pkt) || pkt_valid !== 1'b1) begin bad++; $display("FAIL stall_hold%0d: got v=%b %h exp v=1 %h", c, pkt_valid, pkt_out, enc_f(pkt)); end
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL stall_grant%0d: got %b exp 0000", c, grant); end
    end
    req = 4'b0000;
    out_ready = 1'b1;
    step();
    tok_m = (w + 1) % 4;
    total++; if (pkt_valid !== 1'b0 || token !== 2'(tok_m)) begin bad++; $display("FAIL stall_release: got v=%b tok=%0d exp v=0 tok=%0d", pkt_valid, token, tok_m); end
  endtask

  task automatic test_random;
    logic [28:0] pkt;
    int w;
    int stall;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        req = 4'b0000;
        out_ready = 1'($urandom);
        step();
        total++; if (grant !== 4'b0 || pkt_valid !== 1'b0 || token !== 2'(tok_m)) begin bad++; $display("FAIL rnd_idle%0d: got g=%b v=%b tok=%0d exp g=0000 v=0 tok=%0d", n, grant, pkt_valid, token, tok_m); end
      end
      rand_pkts();
      req = 4'($urandom_range(1, 15));
      out_ready = 1'($urandom);
      w = pick(req, tok_m);
      pkt = node_pkt[29*w +: 29];
      step();
      total++; if (grant !== onehot(w) || enc_in !== pkt) begin bad++; $display("FAIL rnd_grant%0d: got g=%b in=%h exp g=%b in=%h", n, grant, enc_in, onehot(w), pkt); end
      req = 4'($urandom);
      rand_pkts();
      step();
      total++; if (grant !== 4'b0 || pkt_valid !== 1'b1 || pkt_out !== enc_f(pkt)) begin bad++; $display("FAIL rnd_encode%0d: got g=%b v=%b out=%h exp g=0000 v=1 out=%h", n, grant, pkt_valid, pkt_out, enc_f(pkt)); end
      stall = $urandom_range(0, 4);
      for (int c = 0; c < stall; c++) begin
        out_ready = 1'b0;
        req = 4'($urandom);
        step();
        total++; if (pkt_valid !== 1'b1 || pkt_out !== enc_f(pkt) || enc_in !== pkt) begin bad++; $display("FAIL rnd_hold%0d: got v=%b out=%h in=%h exp v=1 out=%h in=%h", n, pkt_valid, pkt_out, enc_in, enc_f(pkt), pkt); end
      end
      out_ready = 1'b1;
      step();
      tok_m = (w + 1) % 4;
      total++; if (pkt_valid !== 1'b0 || token !== 2'(tok_m)) begin bad++; $display("FAIL rnd_done%0d: got v=%b tok=%0d exp v=0 tok=%0d", n, pkt_valid, token, tok_m); end
    end
    req = 4'b0000;
  endtask

  task automatic test_timeout;
    int w;
    rand_pkts();
    req = 4'b0100; out_ready = 1'b0;
    w = pick(req, tok_m);
    step();
    req = 4'b0000;
    step();
`ifdef ENC_TIMEOUT_EN
    for (int k = 1; k < 15; k++) begin
      step();
      total++; if (pkt_valid !== 1'b1 || drop_err !== 1'b0) begin bad++; $display("FAIL to_wait%0d: got v=%b drop=%b exp v=1 drop=0", k, pkt_valid, drop_err); end
    end
    step();
    tok_m = (w + 1) % 4;
    total++; if (pkt_valid !== 1'b0 || drop_err !== 1'b1 || token !== 2'(tok_m)) begin bad++; $display("FAIL to_drop: got v=%b drop=%b tok=%0d exp v=0 drop=1 tok=%0d", pkt_valid, drop_err, token, tok_m); end
    step();
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL to_pulse: got %b exp 0", drop_err); end
`else
    for (int k = 1; k <= 20; k++) begin
      step();
      total++; if (pkt_valid !== 1'b1 || drop_err !== 1'b0 || token !== 2'(tok_m)) begin bad++; $display("FAIL to_wait%0d: got v=%b drop=%b tok=%0d exp v=1 drop=0 tok=%0d", k, pkt_valid, drop_err, token, tok_m); end
    end
    out_ready = 1'b1;
    step();
    tok_m = (w + 1) % 4;
    total++; if (pkt_valid !== 1'b0 || token !== 2'(tok_m)) begin bad++; $display("FAIL to_release: got v=%b tok=%0d exp v=0 tok=%0d", pkt_valid, token, tok_m); end
`endif
  endtask

  task automatic test_async_reset;
    rand_pkts();
    req = 4'b0010; out_ready = 1'b0;
    step();
    req = 4'b0000;
    step();
    total++; if (pkt_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid: got %b exp 1", pkt_valid); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (grant !== 4'b0 || enc_in !== 29'b0 || pkt_out !== 55'b0) begin bad++; $display("FAIL ar_data: got g=%b in=%h out=%h exp zeros", grant, enc_in, pkt_out); end
    total++; if (pkt_valid !== 1'b0 || token !== 2'd0 || drop_err !== 1'b0) begin bad++; $display("FAIL ar_ctrl: got v=%b tok=%0d drop=%b exp 0 0 0", pkt_valid, token, drop_err); end
    rst = 1'b0;
    tok_m = 0;
    out_ready = 1'b1;
    step();
    total++; if (grant !== 4'b0 || pkt_valid !== 1'b0 || token !== 2'd0) begin bad++; $display("FAIL ar_after: got g=%b v=%b tok=%0d exp 0000 0 0", grant, pkt_valid, token); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wrap();
    test_round_robin();
    test_stall();
    test_random();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encode_scheduler.md
ENCODE_SCHEDULER -- requirements
Module: encode_scheduler

Interface
REQ-001 SHALL have parameter: NODES, 4, number of requesting nodes (fixed at 4; token pointer is 2 bits).
REQ-002 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req  input  4  per-node request, level, bit i = node i.
REQ-005 SHALL have ports: node_pkt  input  116  node packets, node i at bits [29*i+28 : 29*i].
REQ-006 SHALL have ports: grant  output  4  one-hot acknowledge pulse to winning node.
REQ-007 SHALL have ports: enc_in  output  29  registered packet driven into the shared encoder datapath.
REQ-008 SHALL have ports: enc_pkt  input  55  encoded packet returned combinationally by the encoder.
REQ-009 SHALL have ports: pkt_out  output  55  registered encoded packet.
REQ-010 SHALL have ports: pkt_valid  output  1  pkt_out holds a packet.
REQ-011 SHALL have ports: out_ready  input  1  downstream accepts pkt_out.
REQ-012 SHALL have ports: token  output  2  current round-robin token position.
REQ-013 SHALL have ports: drop_err  output  1  one-cycle pulse on timeout drop (0 when ENC_TIMEOUT_EN undefined).

Function
REQ-014 SHALL implement FSM states IDLE, ENCODE, HOLD.
REQ-015 IDLE: if req nonzero, SHALL pick winner w = first set bit searching token, token+1, ... mod 4; at the edge, grant<=onehot(w), enc_in<=node_pkt slice w, latch w, go ENCODE.
REQ-016 IDLE with req==0: SHALL hold all state; grant stays 0.
REQ-017 ENCODE: SHALL at the edge set pkt_out<=enc_pkt, pkt_valid<=1, grant<=0, go HOLD.
REQ-018 HOLD: pkt_valid and pkt_out SHALL stay stable until out_ready sampled 1.
REQ-019 HOLD with out_ready=1: SHALL set pkt_valid<=0, token<=(w+1) mod 4, go IDLE.
REQ-020 grant SHALL be high exactly one cycle per accepted packet, the cycle after the IDLE decision.
REQ-021 Latency: req seen in IDLE at edge N -> grant high N..N+1, pkt_valid high from edge N+1; minimum 3 cycles per packet.
REQ-022 req changes during ENCODE/HOLD SHALL be ignored; new arbitration only in IDLE.
REQ-023 Token SHALL wrap 3->0; token only advances on a completed or dropped packet.
REQ-024 enc_in SHALL retain last value outside IDLE-grant edges.
REQ-025 out_ready while pkt_valid=0 SHALL have no effect.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, token 0, grant 0, enc_in 0, pkt_out 0, pkt_valid 0, drop_err 0, timeout counter 0.
REQ-027 Reset mid-HOLD SHALL discard the held packet without advancing token beyond 0.
REQ-028 First arbitration SHALL occur on first rising edge with rst=0.

Configuration
REQ-029 Macro ENC_TIMEOUT_EN defined: 4-bit counter clears on HOLD entry, increments each HOLD cycle with out_ready=0; on reaching 15 SHALL clear pkt_valid, pulse drop_err one cycle, advance token to (w+1) mod 4, go IDLE.
REQ-030 ENC_TIMEOUT_EN undefined: no counter, HOLD waits indefinitely, drop_err tied 0.

Verification
REQ-031 Reset then req=4'b0100, node2 pkt=29'h1ABCDE0, out_ready=1 -> enc_in=29'h1ABCDE0, grant=4'b0100 one cycle, pkt_out=enc_pkt, pkt_valid one cycle, token=3.
REQ-032 token=0, req=4'b1111 held, out_ready=1 -> grants 0001,0010,0100,1000,0001 in order, every 3 cycles.
REQ-033 token=3, req=4'b0011 -> grant 0001 first, token becomes 1, next grant 0010.
REQ-034 out_ready=0 for 5 cycles in HOLD -> pkt_out stable, grant 0, req changes ignored; out_ready=1 -> IDLE next edge.
REQ-035 ENC_TIMEOUT_EN defined, out_ready=0 held -> drop_err pulses 15 cycles after HOLD entry, pkt_valid falls, token advances; undefined -> pkt_valid stays 1.
REQ-036 Assert rst asynchronously mid-HOLD -> all outputs 0 before next clock edge, token=0.
